// File: rtl/per_bus_master.sv
// Single-outstanding command master for a simple strobe-based peripheral bus.
// Commands are size/alignment checked, issued as one-cycle strobes, and answered once.
module per_bus_master (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [1:0]  cmd_size_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_write_o,
  output logic [15:0] per_addr_o,
  output logic [31:0] per_wdata_o,
  output logic [1:0]  per_size_o,
  output logic        per_rd_o,
  output logic        per_wr_o,
  input  logic [31:0] per_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic        accept;
  logic        cmd_err;
  logic [15:0] per_addr_reg;
  logic [31:0] per_wdata_reg;
  logic [1:0]  per_size_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;
  logic        rsp_write_reg;

  // Ready is held low while reset is asserted, even though the state is already IDLE.
  assign cmd_ready_o = (state_reg == IDLE) && !reset_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_comb begin
    cmd_err = 1'b0;
    case (cmd_size_i)
      2'd1:    cmd_err = cmd_addr_i[0];
      2'd2:    cmd_err = (cmd_addr_i[1:0] != 2'b00);
      2'd3:    cmd_err = 1'b1;
      default: cmd_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = cmd_err ? RESP : ISSUE;
      ISSUE:   state_next = rsp_write_reg ? RESP : WAIT;
      WAIT:    state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Rejected commands leave the peripheral-side registers untouched.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      per_addr_reg  <= 16'h0000;
      per_wdata_reg <= 32'h0000_0000;
      per_size_reg  <= 2'd0;
      rsp_rdata_reg <= 32'h0000_0000;
      rsp_err_reg   <= 1'b0;
      rsp_write_reg <= 1'b0;
    end else begin
      if (accept) begin
        rsp_write_reg <= cmd_write_i;
        rsp_err_reg   <= cmd_err;
        rsp_rdata_reg <= 32'h0000_0000;
        if (!cmd_err) begin
          per_addr_reg  <= cmd_addr_i;
          per_wdata_reg <= cmd_wdata_i;
          per_size_reg  <= cmd_size_i;
        end
      end
      if (state_reg == WAIT) rsp_rdata_reg <= per_rdata_i;
    end
  end

  assign per_rd_o    = (state_reg == ISSUE) && !rsp_write_reg;
  assign per_wr_o    = (state_reg == ISSUE) &&  rsp_write_reg;
  assign rsp_valid_o = (state_reg == RESP);
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign rsp_write_o = rsp_write_reg;
  assign per_addr_o  = per_addr_reg;
  assign per_wdata_o = per_wdata_reg;
  assign per_size_o  = per_size_reg;

endmodule

// File: tb/tb_per_bus_master.sv
// Directed bench for per_bus_master: stimulus on falling edges, outputs sampled on falling edges.
module tb_per_bus_master;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic [15:0] cmd_addr_i = 16'h0;
  logic [31:0] cmd_wdata_i = 32'h0;
  logic [1:0]  cmd_size_i = 2'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_write_o;
  logic [15:0] per_addr_o;
  logic [31:0] per_wdata_o;
  logic [1:0]  per_size_o;
  logic        per_rd_o;
  logic        per_wr_o;
  logic [31:0] per_rdata_i = 32'h0;

  int checks = 0;
  int errors = 0;

  per_bus_master dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_size_i(cmd_size_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_write_o(rsp_write_o),
    .per_addr_o(per_addr_o), .per_wdata_o(per_wdata_o), .per_size_o(per_size_o),
    .per_rd_o(per_rd_o), .per_wr_o(per_wr_o), .per_rdata_i(per_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({cmd_ready_o, rsp_valid_o, per_rd_o, per_wr_o, rsp_err_o, rsp_write_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {cmd_ready_o, rsp_valid_o, per_rd_o, per_wr_o, rsp_err_o, rsp_write_o});
    end
    checks++;
    if ({rsp_rdata_o, per_addr_o, per_wdata_o, per_size_o} !== 82'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h size=%0d expected all 0",
               rsp_rdata_o, per_addr_o, per_wdata_o, per_size_o);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", cmd_ready_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_write();
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 16'h0004;
    cmd_wdata_i = 32'h12345678; cmd_size_i = 2'd2; rsp_ready_i = 1'b0;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    checks++;
    if ({per_wr_o, per_rd_o, rsp_valid_o, cmd_ready_o} !== 4'b1000 ||
        per_addr_o !== 16'h0004 || per_wdata_o !== 32'h12345678 || per_size_o !== 2'd2) begin
      errors++;
      $display("FAIL write_issue: got wr/rd/vld/rdy=%b addr=%h wdata=%h size=%0d expected 1000 0004 12345678 2",
               {per_wr_o, per_rd_o, rsp_valid_o, cmd_ready_o}, per_addr_o, per_wdata_o, per_size_o);
    end
    @(negedge clk_i);
    checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_write_o, per_wr_o} !== 4'b1010 || rsp_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL write_resp: got vld/err/wr/strobe=%b rdata=%h expected 1010 00000000",
               {rsp_valid_o, rsp_err_o, rsp_write_o, per_wr_o}, rsp_rdata_o);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checks++;
    if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL write_handshake: got vld/rdy=%b expected 01", {rsp_valid_o, cmd_ready_o});
    end
    $display("test_write: addr=0004 data=12345678 done");
  endtask

  // per_rdata_i carries junk in every cycle except WAIT.
  task automatic test_read_capture();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0000;
    cmd_wdata_i = 32'hCAFEF00D; cmd_size_i = 2'd2; per_rdata_i = 32'hDEAD0001;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    per_rdata_i = 32'hDEAD0002;
    checks++;
    if ({per_rd_o, per_wr_o, rsp_valid_o} !== 3'b100 || per_addr_o !== 16'h0000 ||
        per_wdata_o !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL read_issue: got rd/wr/vld=%b addr=%h wdata=%h expected 100 0000 cafef00d",
               {per_rd_o, per_wr_o, rsp_valid_o}, per_addr_o, per_wdata_o);
    end
    @(negedge clk_i);
    per_rdata_i = 32'h00000005;
    checks++;
    if ({per_rd_o, per_wr_o, rsp_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL read_wait: got rd/wr/vld=%b expected 000", {per_rd_o, per_wr_o, rsp_valid_o});
    end
    @(negedge clk_i);
    per_rdata_i = 32'hDEAD0003;
    checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_write_o} !== 3'b100 || rsp_rdata_o !== 32'h00000005) begin
      errors++;
      $display("FAIL read_resp: got vld/err/wr=%b rdata=%h expected 100 00000005",
               {rsp_valid_o, rsp_err_o, rsp_write_o}, rsp_rdata_o);
    end
    @(negedge clk_i);
    per_rdata_i = 32'hDEAD0004;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h00000005) begin
      errors++;
      $display("FAIL read_hold: got vld=%b rdata=%h expected 1 00000005", rsp_valid_o, rsp_rdata_o);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    $display("test_read_capture: rdata=%h", rsp_rdata_o);
  endtask

  task automatic test_errors();
    logic [15:0] addrs [3] = '{16'h0002, 16'h0000, 16'h0001};
    logic [1:0]  sizes [3] = '{2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 3; i++) begin
      cmd_valid_i = 1'b1; cmd_write_i = i[0]; cmd_addr_i = addrs[i];
      cmd_wdata_i = 32'hAAAAAAAA; cmd_size_i = sizes[i];
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      checks++;
      if ({rsp_valid_o, rsp_err_o, per_rd_o, per_wr_o} !== 4'b1100 || rsp_rdata_o !== 32'h0 ||
          rsp_write_o !== i[0]) begin
        errors++;
        $display("FAIL err_resp_%0d: got vld/err/rd/wr=%b rdata=%h write=%b expected 1100 00000000 %b",
                 i, {rsp_valid_o, rsp_err_o, per_rd_o, per_wr_o}, rsp_rdata_o, rsp_write_o, i[0]);
      end
      checks++;
      if (per_addr_o !== 16'h0000 || per_wdata_o !== 32'hCAFEF00D || per_size_o !== 2'd2) begin
        errors++;
        $display("FAIL err_regs_%0d: got addr=%h wdata=%h size=%0d expected 0000 cafef00d 2",
                 i, per_addr_o, per_wdata_o, per_size_o);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      $display("test_errors: addr=%h size=%0d err=1", addrs[i], sizes[i]);
    end
  endtask

  task automatic test_stall();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0008;
    cmd_wdata_i = 32'h0; cmd_size_i = 2'd2; per_rdata_i = 32'h11223344;
    @(negedge clk_i);
    // A competing command is held on the inputs; it must be ignored.
    cmd_write_i = 1'b1; cmd_addr_i = 16'h0040; cmd_wdata_i = 32'h55555555;
    @(negedge clk_i);
    @(negedge clk_i);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_write_o, cmd_ready_o, per_rd_o, per_wr_o} !== 6'b100000 ||
          rsp_rdata_o !== 32'h11223344 || per_addr_o !== 16'h0008) begin
        errors++;
        $display("FAIL stall_%0d: got vld/err/wr/rdy/rd/wr=%b rdata=%h addr=%h expected 100000 11223344 0008",
                 c, {rsp_valid_o, rsp_err_o, rsp_write_o, cmd_ready_o, per_rd_o, per_wr_o},
                 rsp_rdata_o, per_addr_o);
      end
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    $display("test_stall: held 10 cycles rdata=%h", rsp_rdata_o);
  endtask

  task automatic test_back_to_back();
    logic        wr  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] adr [4] = '{16'h0030, 16'h0006, 16'h0003, 16'h0005};
    logic [1:0]  sz  [4] = '{2'd2, 2'd1, 2'd0, 2'd1};
    logic [31:0] dat [4] = '{32'hA5A5A5A5, 32'h0000BEEF, 32'h00000077, 32'h0};
    logic [31:0] exp_rd [4] = '{32'h0, 32'h0000BEEF, 32'h00000077, 32'h0};
    logic        exp_err [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int          exp_lat [4] = '{2, 3, 3, 1};
    int cycles, rd_cnt, wr_cnt;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: got %b expected 1", i, cmd_ready_o);
      end
      cmd_valid_i = 1'b1; cmd_write_i = wr[i]; cmd_addr_i = adr[i];
      cmd_wdata_i = dat[i]; cmd_size_i = sz[i]; per_rdata_i = dat[i];
      cycles = 0; rd_cnt = 0; wr_cnt = 0;
      do begin
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cycles++;
        rd_cnt += int'(per_rd_o);
        wr_cnt += int'(per_wr_o);
      end while (rsp_valid_o !== 1'b1 && cycles < 8);
      checks++;
      if (cycles != exp_lat[i] || rsp_err_o !== exp_err[i] || rsp_rdata_o !== exp_rd[i] ||
          rsp_write_o !== wr[i]) begin
        errors++;
        $display("FAIL b2b_resp_%0d: got lat=%0d err=%b rdata=%h write=%b expected %0d %b %h %b",
                 i, cycles, rsp_err_o, rsp_rdata_o, rsp_write_o, exp_lat[i], exp_err[i], exp_rd[i], wr[i]);
      end
      checks++;
      if (rd_cnt != int'(!wr[i] && !exp_err[i]) || wr_cnt != int'(wr[i] && !exp_err[i])) begin
        errors++;
        $display("FAIL b2b_strobes_%0d: got rd=%0d wr=%0d expected %0d %0d", i, rd_cnt, wr_cnt,
                 int'(!wr[i] && !exp_err[i]), int'(wr[i] && !exp_err[i]));
      end
      @(negedge clk_i);
      checks++;
      if (rsp_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b_dup_%0d: got rsp_valid=%b expected 0", i, rsp_valid_o);
      end
      $display("test_back_to_back: cmd %0d addr=%h lat=%0d err=%b rdata=%h",
               i, adr[i], cycles, rsp_err_o, rsp_rdata_o);
    end
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 16'h0010;
    cmd_size_i = 2'd2; per_rdata_i = 32'h99999999;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if ({per_rd_o, per_wr_o, rsp_valid_o, cmd_ready_o} !== 4'b0000 || rsp_rdata_o !== 32'h0 ||
        per_addr_o !== 16'h0) begin
      errors++;
      $display("FAIL rst_wait_async: got rd/wr/vld/rdy=%b rdata=%h addr=%h expected 0000 00000000 0000",
               {per_rd_o, per_wr_o, rsp_valid_o, cmd_ready_o}, rsp_rdata_o, per_addr_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    rsp_ready_i = 1'b1;
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_ready: got %b expected 1", cmd_ready_o);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      checks++;
      if ({rsp_valid_o, per_rd_o, per_wr_o} !== 3'b000) begin
        errors++;
        $display("FAIL rst_wait_norsp_%0d: got vld/rd/wr=%b expected 000", c,
                 {rsp_valid_o, per_rd_o, per_wr_o});
      end
    end
    rsp_ready_i = 1'b0;
    $display("test_reset_in_wait done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_capture();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/per_bus_master.md
PER_BUS_MASTER -- requirements
Module: per_bus_master

Interface
REQ-001 SHALL have no parameters; address width is fixed at 16 bits and data width at 32 bits.
REQ-002 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 reset_i  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  command accepted when both cmd_valid_i and cmd_ready_o are high at a rising edge.
REQ-006 cmd_write_i  input  1  1 = write, 0 = read.
REQ-007 cmd_addr_i  input  16  peripheral byte address.
REQ-008 cmd_wdata_i  input  32  write data.
REQ-009 cmd_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-010 rsp_valid_o  output  1  response available.
REQ-011 rsp_ready_i  input  1  response consumed when both rsp_valid_o and rsp_ready_i are high at a rising edge.
REQ-012 rsp_rdata_o  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err_o  output  1  command rejected, no bus cycle issued.
REQ-014 rsp_write_o  output  1  copy of the cmd_write_i value of the command being answered.
REQ-015 per_addr_o  output  16  peripheral address.
REQ-016 per_wdata_o  output  32  peripheral write data.
REQ-017 per_size_o  output  2  peripheral access size.
REQ-018 per_rd_o  output  1  read strobe, one-cycle pulse.
REQ-019 per_wr_o  output  1  write strobe, one-cycle pulse.
REQ-020 per_rdata_i  input  32  peripheral read data, valid the cycle after per_rd_o.

Function
REQ-021 SHALL use the states IDLE, ISSUE, WAIT and RESP.
REQ-022 cmd_ready_o SHALL be 1 only in IDLE; exactly one command is in flight at a time.
REQ-023 Error check at acceptance: size 3; half with addr[0]=1; word with addr[1:0]!=0.
REQ-024 Erroneous command: IDLE->RESP; rsp_err_o=1, rsp_rdata_o=0; no strobe issued; per_* address, data and size registers unchanged.
REQ-025 Valid command: cmd_addr_i, cmd_wdata_i and cmd_size_i SHALL be registered into per_addr_o, per_wdata_o and per_size_o at the acceptance edge; state IDLE->ISSUE.
REQ-026 ISSUE lasts exactly one cycle and asserts per_wr_o (write) or per_rd_o (read), never both.
REQ-027 Write: ISSUE->RESP; rsp_err_o=0, rsp_rdata_o=0.
REQ-028 Read: ISSUE->WAIT; per_rdata_i is captured into rsp_rdata_o at the edge ending WAIT; WAIT->RESP.
REQ-029 per_rdata_i SHALL be ignored in every state except WAIT.
REQ-030 Latency from the acceptance edge to rsp_valid_o=1: error 1 cycle, write 2 cycles, read 3 cycles.
REQ-031 RESP: rsp_valid_o=1, with rsp_rdata_o, rsp_err_o and rsp_write_o stable until handshake; RESP->IDLE at the handshake edge.
REQ-032 cmd_ready_o SHALL rise in the cycle after the response handshake; best-case throughput is one read per 4 cycles.
REQ-033 per_addr_o, per_wdata_o and per_size_o SHALL hold their last values between transactions; strobes are 0 outside ISSUE.
REQ-034 cmd_* inputs SHALL be ignored when cmd_ready_o=0.
REQ-035 A response SHALL not be dropped or duplicated; exactly one response per accepted command.
REQ-036 Indefinite stall of rsp_ready_i SHALL be tolerated with all outputs held.

Reset
REQ-037 Asserting reset_i SHALL immediately force state IDLE; rsp_valid_o, per_rd_o and per_wr_o to 0; rsp_rdata_o, rsp_err_o and rsp_write_o to 0; per_addr_o, per_wdata_o and per_size_o to 0.
REQ-038 cmd_ready_o SHALL be 0 while reset_i is high and 1 in the first cycle after reset release.
REQ-039 Reset during ISSUE, WAIT or RESP SHALL abandon the transaction; no response for it is emitted after release.

Verification
REQ-040 Write addr 0x0004, data 0x12345678, size 2 -> per_wr_o pulse 1 cycle after acceptance with per_addr_o=0x0004 and per_wdata_o=0x12345678; rsp_valid_o at +2 with rsp_err_o=0, rsp_write_o=1.
REQ-041 Read addr 0x0000 with per_rdata_i=0x00000005 presented in the cycle after per_rd_o -> rsp_rdata_o=0x00000005 and rsp_valid_o at +3.
REQ-042 Word read addr 0x0002; size 3 at addr 0x0000; half at addr 0x0001 -> each rsp_err_o=1 at +1, no strobe, per_addr_o unchanged.
REQ-043 Hold rsp_ready_i=0 for 10 cycles after a read -> rsp_* outputs stable and cmd_ready_o=0 throughout; back-to-back commands afterwards are each answered once, in order.
REQ-044 Assert reset_i during WAIT of a read -> per_rd_o, per_wr_o and rsp_valid_o are 0 immediately; no response after release; cmd_ready_o=1 in the first post-reset cycle.
REQ-045 Vary per_rdata_i every cycle outside WAIT -> captured value equals the WAIT-cycle value only.
